bram_read_fsm: RTL
==================

# bram_read_fsm

Read-side sequencer for the dual-port 48-bit BRAM that the write FSM populates. It walks a block of consecutive words, reading two words per cycle: port A takes even offsets and port B takes odd offsets. It then returns each word with a valid strobe, and pulses `done` when the block is complete. It sits between the BRAM's read ports and the downstream datapath or debug capture logic.

## Interface
- `DATA_W`, 48, BRAM word width
- `ADDR_W`, 10, BRAM address width
- `RD_LAT`, 1, cycles from address presentation to valid `q_a`/`q_b`; legal values 1 or 2
- `clk`  in  1  single clock; all logic on posedge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin a block read; sampled only in IDLE
- `base_addr`  in  ADDR_W  first word address, latched on accepted `start`
- `count`  in  ADDR_W+1  number of words, 0..2^ADDR_W, latched on accepted `start`
- `exp_seed`  in  DATA_W  expected value of word 0, latched on `start` (used only with check feature)
- `q_a`, `q_b`  in  DATA_W  BRAM read data
- `addr_a`, `addr_b`  out  ADDR_W  BRAM addresses (registered)
- `we_a`, `we_b`  out  1  tied 0
- `data_a`, `data_b`  out  DATA_W  BRAM write data; tied 0
- `rd_data_a`, `rd_data_b`  out  DATA_W  captured read words (registered)
- `rd_valid_a`, `rd_valid_b`  out  1  per-port word valid
- `busy`  out  1  high from ISSUE through DRAIN
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  sticky mismatch flag
- `err_cnt`  out  16  mismatch count, saturating at 0xFFFF

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: when `start`=1, latch the inputs and clear `err`/`err_cnt`. If `count`=0, go to DONE; otherwise go to ISSUE.
  - `start` is ignored in every other state.
- ISSUE: for issue step i, drive `addr_a`=base+2i and `addr_b`=base+2i+1.
  - Addresses wrap modulo 2^ADDR_W.
  - On the final step with odd `count`, only port A carries a live read; port B's slot is marked not valid.
  - After ceil(count/2) steps, go to DRAIN.
- DRAIN: wait until the last issued read has been captured, then go to DONE.
- DONE: `done`=1 for one cycle, then return to IDLE.
- A valid-flag pipe, RD_LAT+1 deep and one flag per port, tracks which issued slots are live.
  - Each `rd_data_x` is registered from `q_x` when its pipe flag exits, and `rd_valid_x` pulses with it.
  - Word k (offset k) appears on port A if k is even and on port B if k is odd.
- Word order across a cycle: port A's word precedes port B's word.
- Reset mid-operation: return to IDLE immediately and drop the pipe contents; no `done` and no `rd_valid` is produced afterwards.
- Reset values: `addr_a`=0, `addr_b`=0, `rd_data_a`=0, `rd_data_b`=0. `rd_valid_*`, `busy`, `done`, `err` and `err_cnt` all reset to 0. Write outputs are always 0.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- Cycles 1..S, where S=ceil(count/2): ISSUE; `busy`=1 and addresses for step i are visible in cycle 1+i.
- Read data for step i is valid on `q_*` in cycle 1+i+RD_LAT, and is registered to `rd_*` in cycle 2+i+RD_LAT.
- Last `rd_valid` occurs in cycle S+1+RD_LAT.
- `done` occurs in cycle S+2+RD_LAT with `busy`=0; IDLE resumes the following cycle.
- `count`=0: `done` occurs in cycle 1 and no addresses change.
- Maximum sustained rate is 2 words/cycle.

## Configuration
- `BRAM_RD_CHECK_EN` defined: each valid word k is compared against (`exp_seed`+k) mod 2^DATA_W.
  - On a mismatch, set `err` and increment `err_cnt` in the same cycle as that word's `rd_valid`, saturating at 0xFFFF.
  - If both ports mismatch in one cycle, `err_cnt` increments by 2.
- `BRAM_RD_CHECK_EN` undefined: `err` and `err_cnt` are constant 0, no comparator logic is built, and the ports remain present.

## Test plan
- base=0x010, count=4, RD_LAT=1, BRAM holding 24,25,26,27:
  - Words 24/25 appear in cycle 3 and 26/27 in cycle 4, each with both valids.
  - `done` pulses in cycle 5; `err`=0 with seed=24.
- count=3, RD_LAT=2: the second step has `rd_valid_a`=1 and `rd_valid_b`=0; `done` pulses in cycle 6.
- base=0x3FF, count=2: `addr_a`=0x3FF and `addr_b`=0x000 in cycle 1, and the data returns correctly.
- count=0: `done` pulses in cycle 1 with `busy` never high; a `start` asserted during DONE is ignored.
- Assert `reset` in cycle 2 of a count=8 read: all outputs are 0 the next cycle, with no later `rd_valid` or `done`.
- With `BRAM_RD_CHECK_EN`, seed=24, and words 2 and 3 corrupted: `err`=1 and `err_cnt`=2 after cycle 4. A new `start` clears both.

Source files
------------

// File: rtl/bram_read_fsm.sv
// bram_read_fsm: block reader for a dual-port BRAM, two words per cycle (A=even, B=odd offsets).
// Latency: addresses registered one cycle after start; words on rd_* RD_LAT+1 cycles after their address.
// Backpressure: none; once started the block streams at full rate. Optional checker: BRAM_RD_CHECK_EN.
module bram_read_fsm #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   count_i,
  input  logic [DATA_W-1:0] exp_seed_i,
  input  logic [DATA_W-1:0] q_a_i,
  input  logic [DATA_W-1:0] q_b_i,
  output logic [ADDR_W-1:0] addr_a_o,
  output logic [ADDR_W-1:0] addr_b_o,
  output logic              we_a_o,
  output logic              we_b_o,
  output logic [DATA_W-1:0] data_a_o,
  output logic [DATA_W-1:0] data_b_o,
  output logic [DATA_W-1:0] rd_data_a_o,
  output logic [DATA_W-1:0] rd_data_b_o,
  output logic              rd_valid_a_o,
  output logic              rd_valid_b_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [15:0]       err_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W-1:0] ADDR_TWO = 2;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W:0]   CNT_TWO  = 2;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [ADDR_W:0]   left_q, left_d;      // words not yet issued
  logic              issue_a, issue_b;    // live flags for the slot being issued
  logic              accept;              // start taken this cycle
  logic [RD_LAT:0]   pipe_a_q, pipe_b_q;  // stage 0 pairs with the address register
  logic [DATA_W-1:0] rd_data_a_q, rd_data_b_q;
  logic              rd_valid_a_q, rd_valid_b_q;

  // Next-state, address stepping and slot liveness.
  always_comb begin
    state_d  = state_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    left_d   = left_q;
    issue_a  = 1'b0;
    issue_b  = 1'b0;
    accept   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          accept = 1'b1;
          if (count_i == '0) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_ISSUE;
            addr_a_d = base_addr_i;
            addr_b_d = base_addr_i + ADDR_ONE;
            issue_a  = 1'b1;
            issue_b  = (count_i >= CNT_TWO);
            left_d   = issue_b ? (count_i - CNT_TWO) : (count_i - CNT_ONE);
          end
        end
      end
      S_ISSUE: begin
        if (left_q == '0) begin
          state_d = S_DRAIN;
        end else begin
          addr_a_d = addr_a_q + ADDR_TWO;
          addr_b_d = addr_b_q + ADDR_TWO;
          issue_a  = 1'b1;
          issue_b  = (left_q >= CNT_TWO);
          left_d   = issue_b ? (left_q - CNT_TWO) : (left_q - CNT_ONE);
        end
      end
      S_DRAIN: begin
        // Port A is live on every issued step, so its pipe alone tells when all reads landed.
        if (pipe_a_q == '0) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, address and valid-pipe registers; reset drops any in-flight reads.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      addr_a_q <= '0;
      addr_b_q <= '0;
      left_q   <= '0;
      pipe_a_q <= '0;
      pipe_b_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      left_q   <= left_d;
      pipe_a_q <= {pipe_a_q[RD_LAT-1:0], issue_a};
      pipe_b_q <= {pipe_b_q[RD_LAT-1:0], issue_b};
    end
  end

  // Capture read data as its pipe flag exits; valid pulses alongside.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
    end else begin
      rd_valid_a_q <= pipe_a_q[RD_LAT];
      rd_valid_b_q <= pipe_b_q[RD_LAT];
      if (pipe_a_q[RD_LAT]) rd_data_a_q <= q_a_i;
      if (pipe_b_q[RD_LAT]) rd_data_b_q <= q_b_i;
    end
  end

`ifdef BRAM_RD_CHECK_EN
  localparam logic [DATA_W-1:0] EXP_ONE = 1;
  localparam logic [DATA_W-1:0] EXP_TWO = 2;

  logic [DATA_W-1:0] exp_q;      // expected value of the next port-A word
  logic              err_q;
  logic [15:0]       err_cnt_q;
  logic              mis_a, mis_b;
  logic [16:0]       cnt_sum;

  // Compare words as they are captured; B always carries the word after A.
  always_comb begin
    mis_a   = pipe_a_q[RD_LAT] && (q_a_i != exp_q);
    mis_b   = pipe_b_q[RD_LAT] && (q_b_i != (exp_q + EXP_ONE));
    cnt_sum = {1'b0, err_cnt_q} + 17'(mis_a) + 17'(mis_b);
  end

  // Sticky error flag and saturating mismatch counter, cleared by an accepted start.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      exp_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else if (accept) begin
      exp_q     <= exp_seed_i;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (pipe_a_q[RD_LAT]) exp_q <= exp_q + (pipe_b_q[RD_LAT] ? EXP_TWO : EXP_ONE);
      if (mis_a || mis_b) err_q <= 1'b1;
      err_cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;
`else
  logic unused_seed;
  logic unused_accept;
  assign unused_seed   = ^exp_seed_i;
  assign unused_accept = accept;
  assign err_o         = 1'b0;
  assign err_cnt_o     = '0;
`endif

  assign addr_a_o     = addr_a_q;
  assign addr_b_o     = addr_b_q;
  assign we_a_o       = 1'b0;
  assign we_b_o       = 1'b0;
  assign data_a_o     = '0;
  assign data_b_o     = '0;
  assign rd_data_a_o  = rd_data_a_q;
  assign rd_data_b_o  = rd_data_b_q;
  assign rd_valid_a_o = rd_valid_a_q;
  assign rd_valid_b_o = rd_valid_b_q;
  assign busy_o       = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done_o       = (state_q == S_DONE);

endmodule
